instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch-side initiator for the asynchronous instruction memory. Holds the program counter and drives the word-aligned byte address into the memory. Waits a fixed number of clock cycles for the memory's propagation delay to settle, then captures the returned word and offers it to the decode stage over a valid/ready handshake. Sits between the instruction memory and the decoder, and accepts branch/jump redirects from the execute stage.

## Interface
- `ADDR_W`, 32: address and PC width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 32'h0000_0000: first fetch address; must be 4-byte aligned.
- `MEM_WAIT`, 4: clock cycles from an address change to a valid sample; ≥1. `MEM_WAIT` × Tclk must exceed the memory's access delay.

- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `mem_address` out ADDR_W: byte address presented to the instruction memory.
- `mem_instruction` in DATA_W: word returned by the memory, combinational with its delay.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_target` in ADDR_W: new PC; bits [1:0] are ignored (forced 0).
- `out_valid` out 1: `out_instruction` and `out_pc` are valid.
- `out_ready` in 1: decoder accepts this cycle.
- `out_instruction` out DATA_W: captured instruction.
- `out_pc` out ADDR_W: address the instruction was fetched from.
- `fetch_count` out 32: number of completed handshakes; wraps modulo 2^32.

## Operation
- Two states: WAIT and HOLD. A down-counter `cnt` of width clog2(`MEM_WAIT`) runs in WAIT.
- Reset (priority over everything) sets:
  - state = WAIT, `cnt` = `MEM_WAIT`-1
  - `mem_address` = `RESET_PC`
  - `out_valid` = 0, `out_instruction` = 0, `out_pc` = 0, `fetch_count` = 0
- WAIT, `cnt` ≠ 0: decrement `cnt`.
- WAIT, `cnt` = 0:
  - `out_instruction` ← `mem_instruction`, `out_pc` ← `mem_address`, `out_valid` ← 1
  - go to HOLD.
- HOLD, `out_ready` = 0: all outputs hold. `mem_address` stays stable, so the captured word stays coherent.
- HOLD, `out_ready` = 1 (handshake):
  - `fetch_count` += 1
  - `mem_address` += 4 (wraps at 2^ADDR_W, so 0xFFFF_FFFC → 0)
  - `out_valid` ← 0, `cnt` ← `MEM_WAIT`-1, go to WAIT.
- Redirect (`redirect_valid` = 1), any state:
  - `mem_address` ← {`redirect_target`[ADDR_W-1:2], 2'b00}
  - `out_valid` ← 0, `cnt` ← `MEM_WAIT`-1, go to WAIT.
  - In WAIT, the in-flight fetch is discarded.
- Redirect together with a handshake in HOLD: the transfer counts (`fetch_count` increments, since the decoder took the word). The next address is the redirect target, not PC+4.
- `out_valid` never drops without a handshake, except on redirect or reset.

## Timing
- First `out_valid` = 1 at the `MEM_WAIT`-th rising edge after the first edge with `rst` = 0.
- Redirect-to-valid latency is `MEM_WAIT` cycles, counted from the edge that samples `redirect_valid`.
- With `out_ready` held at 1, steady throughput is one instruction per `MEM_WAIT`+1 cycles.
- `mem_address` changes only on a handshake, a redirect, or reset, and it is registered (glitch-free).
- All outputs are registered. No combinational path from `out_ready` or `redirect_*` to any output.

## Structure
- Package `fetch_pkg` holds:
  - state enum `fetch_state_t` {WAIT, HOLD}
  - constant `INSTR_BYTES` = 4
  - alignment mask constant
- Optional sub-module `fetch_wait_timer`: a load/decrement counter with `load`, `done`, and `MEM_WAIT` as its parameter. Everything else stays in the top module.

## Test plan
Defaults: `MEM_WAIT`=4, `RESET_PC`=0. The behavioural memory model returns word i = 32'hA000_0000+i after 35 ns, with a 10 ns clock.
- Release reset, `out_ready`=1 → valid at cycle 4 with `out_pc`=0, data A000_0000. Then `out_pc` 4, 8 arrive every 5 cycles, and `fetch_count` goes 1, 2, 3.
- Hold `out_ready`=0 for 10 cycles in HOLD → `out_valid`, `out_instruction`, `out_pc`, `mem_address` stay constant; `fetch_count` is unchanged.
- Redirect to 32'h0000_0043 at cycle 2 of WAIT → `mem_address`=0x40 next cycle, no valid for the old fetch. Valid arrives 4 cycles later with `out_pc`=0x40 and data A000_0010.
- Redirect to 0x20 in the same cycle as a HOLD handshake → `fetch_count` increments by 1, and the next `out_pc`=0x20 (not PC+4).
- Redirect to 0xFFFF_FFFC, then accept → `mem_address` wraps to 0x0000_0000, and the next `out_pc`=0.
- Assert `rst` in HOLD with `out_ready`=1 → on the next edge all outputs are at their reset values and `fetch_count`=0; the first valid comes 4 cycles after release.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    // WAIT: memory address settling; HOLD: captured word offered to decode.
    typedef enum logic {
        WAIT = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // Every instruction is one 32-bit word.
    localparam int INSTR_BYTES = 4;

    // Low address bits cleared to keep fetch addresses word-aligned.
    localparam logic [1:0] ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_wait_timer.sv
// Load/decrement counter timing the memory settle window after an address change.
module fetch_wait_timer #(
    parameter int MEM_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int CNT_W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;

    logic [CNT_W-1:0] cnt;

    // Reload on reset or a new address; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= CNT_W'(MEM_WAIT - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the PC into the async memory, waits for it to
// settle, then offers the word to decode over valid/ready. Redirects from
// execute override the sequential PC at any time.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MEM_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_instruction,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       fetch_count
);

    fetch_state_t state, state_next;
    logic         handshake;
    logic         timer_done;
    logic         capture;

    assign handshake = (state == HOLD) && out_ready;
    // A redirect landing on the settle edge discards the stale word.
    assign capture   = (state == WAIT) && timer_done && !redirect_valid;

    // Any address change restarts the settle window.
    fetch_wait_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (redirect_valid || handshake),
        .done (timer_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT;
        else     state <= state_next;
    end

    // Next state: settle then hold; a handshake or redirect returns to WAIT.
    always_comb begin
        state_next = state;
        case (state)
            WAIT:    if (timer_done) state_next = HOLD;
            HOLD:    if (out_ready)  state_next = WAIT;
            default: state_next = WAIT;
        endcase
        if (redirect_valid) state_next = WAIT;
    end

    // PC, capture registers and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_address     <= RESET_PC;
            out_valid       <= 1'b0;
            out_instruction <= '0;
            out_pc          <= '0;
            fetch_count     <= '0;
        end else begin
            // The decoder took the word even if a redirect arrives alongside.
            if (handshake) fetch_count <= fetch_count + 32'd1;

            if (redirect_valid)
                mem_address <= {redirect_target[ADDR_W-1:2], redirect_target[1:0] & ~ALIGN_MASK};
            else if (handshake)
                mem_address <= mem_address + ADDR_W'(INSTR_BYTES);

            if (capture) begin
                out_instruction <= mem_instruction;
                out_pc          <= mem_address;
                out_valid       <= 1'b1;
            end else if (redirect_valid || handshake) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed stimulus pushes expected transfers into
// a scoreboard; a negedge monitor pops and compares on each handshake.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] mem_address;
    logic [31:0] mem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [31:0] fetch_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    int          exp_count = 0;
    int          c;

    instr_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .mem_address     (mem_address),
        .mem_instruction (mem_instruction),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instruction (out_instruction),
        .out_pc          (out_pc),
        .fetch_count     (fetch_count)
    );

    // Async memory: word i = A000_0000 + i, settling 35 time units after the address.
    assign #35 mem_instruction = 32'hA000_0000 + {2'b00, mem_address[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        sb.push_back(e);
    endtask

    // Advance until out_valid rises (bounded); n returns cycles taken.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 30);
        check("wait_valid timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"},       32'(out_valid), 32'd0);
        check({tag, " out_instruction"}, out_instruction, 32'd0);
        check({tag, " out_pc"},          out_pc,          32'd0);
        check({tag, " fetch_count"},     fetch_count,     32'd0);
        check({tag, " mem_address"},     mem_address,     32'd0);
    endtask

    // Monitor: every accepted transfer must match the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            exp_count = 0;
        end else if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: unexpected transfer pc=%h instr=%h", out_pc, out_instruction);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("xfer out_pc", out_pc, e.pc);
                check("xfer out_instruction", out_instruction, e.instr);
                check("xfer fetch_count", fetch_count, 32'(exp_count));
            end
            exp_count++;
        end
    end

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        tick();
        tick();
        check_reset_state("reset");

        // Sequential fetch with out_ready held high.
        push(32'h0, 32'hA000_0000);
        push(32'h4, 32'hA000_0001);
        push(32'h8, 32'hA000_0002);
        rst = 1'b0;
        repeat (3) tick();
        check("first valid early", 32'(out_valid), 32'd0);
        tick();
        check("first valid", 32'(out_valid), 32'd1);
        check("first pc", out_pc, 32'h0);
        wait_valid(c);
        check("interval pc4", 32'(c), 32'd5);
        check("pc4", out_pc, 32'h4);
        wait_valid(c);
        check("interval pc8", 32'(c), 32'd5);
        check("pc8", out_pc, 32'h8);
        out_ready = 1'b0;

        // Back-pressure: everything holds.
        repeat (10) begin
            tick();
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold out_pc", out_pc, 32'h8);
            check("hold out_instruction", out_instruction, 32'hA000_0002);
            check("hold mem_address", mem_address, 32'h8);
            check("hold fetch_count", fetch_count, 32'd2);
        end

        // Accept, then redirect mid-WAIT to an unaligned target.
        out_ready = 1'b1;
        tick();
        check("post-hold fetch_count", fetch_count, 32'd3);
        check("post-hold mem_address", mem_address, 32'hC);
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0043;
        out_ready       = 1'b0;
        push(32'h40, 32'hA000_0010);
        tick();
        redirect_valid = 1'b0;
        check("redir mem_address", mem_address, 32'h40);
        check("redir out_valid", 32'(out_valid), 32'd0);
        repeat (3) begin
            tick();
            check("redir no stale valid", 32'(out_valid), 32'd0);
        end
        tick();
        check("redir valid", 32'(out_valid), 32'd1);
        check("redir pc", out_pc, 32'h40);
        check("redir instr", out_instruction, 32'hA000_0010);

        // Redirect together with a handshake.
        out_ready       = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h20;
        push(32'h20, 32'hA000_0008);
        tick();
        redirect_valid = 1'b0;
        check("redir+hs fetch_count", fetch_count, 32'd4);
        check("redir+hs mem_address", mem_address, 32'h20);
        check("redir+hs out_valid", 32'(out_valid), 32'd0);
        wait_valid(c);
        check("redir+hs latency", 32'(c), 32'd4);
        check("redir+hs pc", out_pc, 32'h20);
        tick();
        check("pc20 accepted count", fetch_count, 32'd5);
        check("pc24 address", mem_address, 32'h24);

        // Redirect to the top word, then wrap on accept.
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC, 32'hDFFF_FFFF);
        tick();
        redirect_valid = 1'b0;
        check("top mem_address", mem_address, 32'hFFFF_FFFC);
        wait_valid(c);
        check("top latency", 32'(c), 32'd4);
        check("top pc", out_pc, 32'hFFFF_FFFC);
        tick();
        check("wrap mem_address", mem_address, 32'h0);
        check("wrap fetch_count", fetch_count, 32'd6);
        wait_valid(c);
        check("wrap pc", out_pc, 32'h0);
        check("wrap instr", out_instruction, 32'hA000_0000);

        // Reset while holding with out_ready high.
        rst = 1'b1;
        tick();
        check_reset_state("hold reset");
        rst = 1'b0;
        push(32'h0, 32'hA000_0000);
        repeat (3) tick();
        check("rerun valid early", 32'(out_valid), 32'd0);
        tick();
        check("rerun valid", 32'(out_valid), 32'd1);
        check("rerun pc", out_pc, 32'h0);
        tick();
        check("rerun fetch_count", fetch_count, 32'd1);
        repeat (3) tick();
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
